// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the CDC handshake endpoints.
//   hs_state_t      source FSM state encoding
//   MODE_4PH/2PH    handshake protocol selectors for the MODE parameter
//   level_width()   bit width of an occupancy counter for a given depth
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_ACK = 2'b01,
        ST_WAIT_REL = 2'b11
    } hs_state_t;

    localparam int MODE_4PH = 0;
    localparam int MODE_2PH = 1;

    // Occupancy must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser, reset to 0.
//   i_clk   destination clock
//   i_rstn  asynchronous active-low reset
//   i_d     asynchronous input bit
//   o_q     synchronised bit, STAGES flops after i_d
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side endpoint of a CDC request/acknowledge channel. Words from a
// valid/ready producer are queued in a small FIFO, then launched one at a
// time on a held-stable bus qualified by a request level.
//   i_clk, i_rstn      source clock, asynchronous active-low reset
//   i_data, i_valid    producer word and strobe
//   o_ready            FIFO not full
//   i_ack              acknowledge from destination (asynchronous)
//   o_req, o_data      request level and launched word (registered)
//   o_done             one-cycle pulse when a transfer completes
//   o_level            FIFO occupancy
//
// state       | meaning
// ST_IDLE     | no transfer open; launches FIFO head if present
// ST_WAIT_ACK | request open, waiting for the synchronised acknowledge
// ST_WAIT_REL | 4-phase only: request dropped, waiting for ack to return to 0
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_ack,
    output logic                          o_req,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_done,
    output logic [level_width(DEPTH)-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [LW-1:0]         r_count;
    hs_state_t             r_state;

    logic w_ack_s;
    logic w_full;
    logic w_push;
    logic w_pop;

    sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_ack),
        .o_q    (w_ack_s)
    );

    assign w_full  = (r_count == LW'(DEPTH));
    assign o_ready = !w_full;
    assign w_push  = i_valid && !w_full;
    assign w_pop   = (r_state == ST_IDLE) && (r_count != '0);
    assign o_level = r_count;

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            o_req   <= 1'b0;
            o_data  <= '0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        o_data  <= r_mem[r_rptr];
                        o_req   <= (MODE == MODE_2PH) ? !o_req : 1'b1;
                        r_state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (MODE == MODE_2PH) begin
                        // Toggle protocol: ack catching up with req closes the transfer.
                        if (w_ack_s == o_req) begin
                            o_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_ack_s) begin
                        o_req   <= 1'b0;
                        r_state <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (!w_ack_s) begin
                        o_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
